// File: rtl/id_ex_alu_issue_if.sv
// id_ex_alu_issue_if: bundle between ID, the hazard unit and EX around the ID/EX issue register.
//   ID side : id_valid, id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op, id_funct3,
//             id_funct7_5, id_rd, id_reg_write
//   Hazard  : stall (hold EX registers), flush (insert bubble)
//   EX side : ex_valid, ex_op_a, ex_op_b, ex_alu_signal, ex_rd, ex_reg_write, ex_illegal
// Modports: master = issue stage (consumes ID/hazard, drives EX), slave = the surrounding pipeline.
interface id_ex_alu_issue_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  id_valid;
   logic [XLEN-1:0]       id_rs1_data;
   logic [XLEN-1:0]       id_rs2_data;
   logic [XLEN-1:0]       id_imm;
   logic                  id_alu_src;
   logic [1:0]            id_alu_op;
   logic [2:0]            id_funct3;
   logic                  id_funct7_5;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  stall;
   logic                  flush;

   logic                  ex_valid;
   logic [XLEN-1:0]       ex_op_a;
   logic [XLEN-1:0]       ex_op_b;
   logic [1:0]            ex_alu_signal;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_reg_write;
   logic                  ex_illegal;

   modport master (
      input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op, id_funct3,
             id_funct7_5, id_rd, id_reg_write, stall, flush,
      output ex_valid, ex_op_a, ex_op_b, ex_alu_signal, ex_rd, ex_reg_write, ex_illegal
   );

   modport slave (
      output id_valid, id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op, id_funct3,
             id_funct7_5, id_rd, id_reg_write, stall, flush,
      input  ex_valid, ex_op_a, ex_op_b, ex_alu_signal, ex_rd, ex_reg_write, ex_illegal
   );
endinterface

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX pipeline register and ALU-control issue stage.
// Captures decoded operands, muxes operand B, decodes the 2-bit ALU select
// (00 add, 01 sub, 10 or, 11 and) and presents registered fields to EX.
// Priority per edge: flush (bubble) > stall (hold) > load.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every EX output
//   bus_io : id_ex_alu_issue_if.master (ID inputs, stall/flush, EX outputs)
module id_ex_alu_issue #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   id_ex_alu_issue_if.master     bus_io
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e                state_q;
   logic [XLEN-1:0]       op_a_q;
   logic [XLEN-1:0]       op_b_q;
   logic [1:0]            alu_sel_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  reg_write_q;
   logic                  illegal_q;

   logic [1:0]            alu_sel_d;
   logic                  illegal_d;
   logic [XLEN-1:0]       op_b_d;

   assign op_b_d = bus_io.id_alu_src ? bus_io.id_imm : bus_io.id_rs2_data;

   always_comb begin
      alu_sel_d = 2'b00;
      illegal_d = 1'b0;
      unique case (bus_io.id_alu_op)
         2'b00: alu_sel_d = 2'b00;
         2'b01: alu_sel_d = 2'b01;
         2'b10: begin
            unique case (bus_io.id_funct3)
               // Bit 30 of an immediate is part of the immediate, so addi never becomes sub.
               3'b000:  alu_sel_d = (bus_io.id_funct7_5 && !bus_io.id_alu_src) ? 2'b01 : 2'b00;
               3'b110:  alu_sel_d = 2'b10;
               3'b111:  alu_sel_d = 2'b11;
               default: illegal_d = 1'b1;
            endcase
         end
         default: illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         op_a_q      <= '0;
         op_b_q      <= '0;
         alu_sel_q   <= 2'b00;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (bus_io.flush) begin
         state_q     <= StEmpty;
         op_a_q      <= '0;
         op_b_q      <= '0;
         alu_sel_q   <= 2'b00;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (!bus_io.stall) begin
         state_q     <= bus_io.id_valid ? StFull : StEmpty;
         op_a_q      <= bus_io.id_rs1_data;
         op_b_q      <= op_b_d;
         alu_sel_q   <= alu_sel_d;
         rd_q        <= bus_io.id_rd;
         // Non-instructions and undecodable ones must never write the register file.
         reg_write_q <= bus_io.id_valid && bus_io.id_reg_write && !illegal_d;
         illegal_q   <= bus_io.id_valid && illegal_d;
      end
   end

   assign bus_io.ex_valid      = (state_q == StFull);
   assign bus_io.ex_op_a       = op_a_q;
   assign bus_io.ex_op_b       = op_b_q;
   assign bus_io.ex_alu_signal = alu_sel_q;
   assign bus_io.ex_rd         = rd_q;
   assign bus_io.ex_reg_write  = reg_write_q;
   assign bus_io.ex_illegal    = illegal_q;

endmodule
